fuzzy_eval_sequencer: RTL and testbench

FUZZY_EVAL_SEQUENCER -- requirements
Module: fuzzy_eval_sequencer

---
 rtl/fuzzy_eval_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_fuzzy_eval_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzzy_eval_sequencer.sv
// Sequencer that drives a fuzzy controller core over MMIO: it writes mode, T and dT,
// starts the core, polls STATUS, then reads back G and hands it downstream.
module fuzzy_eval_sequencer #(
   parameter int POLL_MAX = 20,
   parameter int LAT_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             init_req,
   input  logic             cfg_reg_mode,
   input  logic             cfg_dt_mode,
   output logic             cs,
   output logic             rd,
   output logic             wr,
   output logic [7:0]       addr,
   output logic [7:0]       wdata,
   input  logic [7:0]       rdata,
   output logic             g_valid,
   input  logic             g_ready,
   output logic [7:0]       g_data,
   output logic [LAT_W-1:0] g_lat,
   output logic             err_timeout,
   output logic             busy
);

   localparam int PC_W = $clog2(POLL_MAX + 1);

   localparam logic [7:0] A_STATUS = 8'h00;
   localparam logic [7:0] A_CTRL   = 8'h01;
   localparam logic [7:0] A_T      = 8'h02;
   localparam logic [7:0] A_DT     = 8'h03;
   localparam logic [7:0] A_G      = 8'h04;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_SET_MODE,
      S_WR_T,
      S_WR_DT,
      S_START,
      S_POLL,
      S_RD_G,
      S_OUT
   } state_t;

   state_t state_q, state_d;

   logic [7:0]       t_q;
   logic [7:0]       dt_q;
   logic             reg_q;
   logic             dtm_q;
   logic [7:0]       t_prev_q;
   logic             hist_q;
   logic [PC_W-1:0]  poll_cnt_q;
   logic [7:0]       g_data_q;
   logic [LAT_W-1:0] g_lat_q;
   logic             err_q;
   logic [7:0]       addr_q;
   logic [7:0]       wdata_q;

   logic             acc_cs;
   logic             acc_rd;
   logic             acc_wr;
   logic [7:0]       acc_addr;
   logic [7:0]       acc_wdata;

   logic             idle;
   logic             handshake;
   logic             poll_last;
   logic signed [8:0] diff;
   logic [7:0]       dt_sat;

   assign idle      = (state_q == S_IDLE);
   assign s_ready   = idle & ~init_req & ~rst;
   assign handshake = s_valid & s_ready;
   assign poll_last = (poll_cnt_q == PC_W'(POLL_MAX));

   // 9-bit signed difference, clamped back into the 8-bit range
   assign diff = $signed({s_data[7], s_data}) - $signed({t_prev_q[7], t_prev_q});

   always_comb begin
      dt_sat = diff[7:0];
      if (diff[8] != diff[7]) begin
         dt_sat = diff[8] ? 8'h80 : 8'h7F;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_cs    = 1'b0;
      acc_rd    = 1'b0;
      acc_wr    = 1'b0;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (init_req) begin
               state_d = S_INIT;
            end else if (s_valid) begin
               state_d = S_SET_MODE;
            end
         end
         S_INIT: begin
            acc_cs    = 1'b1;
            acc_wr    = 1'b1;
            acc_addr  = A_CTRL;
            acc_wdata = 8'h08;
            state_d   = S_IDLE;
         end
         S_SET_MODE: begin
            acc_cs    = 1'b1;
            acc_wr    = 1'b1;
            acc_addr  = A_CTRL;
            acc_wdata = {5'b0, dtm_q, reg_q, 1'b0};
            state_d   = S_WR_T;
         end
         S_WR_T: begin
            acc_cs    = 1'b1;
            acc_wr    = 1'b1;
            acc_addr  = A_T;
            acc_wdata = t_q;
            state_d   = dtm_q ? S_START : S_WR_DT;
         end
         S_WR_DT: begin
            acc_cs    = 1'b1;
            acc_wr    = 1'b1;
            acc_addr  = A_DT;
            acc_wdata = dt_q;
            state_d   = S_START;
         end
         S_START: begin
            acc_cs    = 1'b1;
            acc_wr    = 1'b1;
            acc_addr  = A_CTRL;
            acc_wdata = {5'b0, dtm_q, reg_q, 1'b1};
            state_d   = S_POLL;
         end
         S_POLL: begin
            acc_cs   = 1'b1;
            acc_rd   = 1'b1;
            acc_addr = A_STATUS;
            if (rdata[0]) begin
               state_d = S_RD_G;
            end else if (poll_last) begin
               state_d = S_IDLE;
            end
         end
         S_RD_G: begin
            acc_cs   = 1'b1;
            acc_rd   = 1'b1;
            acc_addr = A_G;
            state_d  = S_OUT;
         end
         S_OUT: begin
            if (g_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_q        <= '0;
         dt_q       <= '0;
         reg_q      <= 1'b0;
         dtm_q      <= 1'b0;
         t_prev_q   <= '0;
         hist_q     <= 1'b0;
         poll_cnt_q <= '0;
         g_data_q   <= '0;
         g_lat_q    <= '0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         err_q <= (state_q == S_POLL) & ~rdata[0] & poll_last;
         if (acc_cs) begin
            addr_q <= acc_addr;
         end
         if (acc_wr) begin
            wdata_q <= acc_wdata;
         end
         if (handshake) begin
            t_q      <= s_data;
            reg_q    <= cfg_reg_mode;
            dtm_q    <= cfg_dt_mode;
            dt_q     <= hist_q ? dt_sat : 8'h00;
            t_prev_q <= s_data;
            hist_q   <= 1'b1;
         end
         if (state_q == S_INIT) begin
            hist_q <= 1'b0;
         end
         if (state_q == S_START) begin
            poll_cnt_q <= PC_W'(1);
         end
         if (state_q == S_POLL) begin
            if (rdata[0]) begin
               g_lat_q <= LAT_W'(poll_cnt_q);
            end else if (!poll_last) begin
               poll_cnt_q <= poll_cnt_q + PC_W'(1);
            end
         end
         if (state_q == S_RD_G) begin
            g_data_q <= rdata;
         end
      end
   end

   assign cs          = acc_cs;
   assign rd          = acc_rd;
   assign wr          = acc_wr;
   assign addr        = acc_cs ? acc_addr : addr_q;
   assign wdata       = acc_wr ? acc_wdata : wdata_q;
   assign g_valid     = (state_q == S_OUT);
   assign g_data      = g_data_q;
   assign g_lat       = g_lat_q;
   assign err_timeout = err_q;
   assign busy        = ~idle;

endmodule

// File: tb/tb_fuzzy_eval_sequencer.sv
// Directed bench for fuzzy_eval_sequencer with a behavioural MMIO core model.
module tb_fuzzy_eval_sequencer;

   logic       clk;
   logic       rst;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       init_req;
   logic       cfg_reg_mode;
   logic       cfg_dt_mode;
   logic       cs;
   logic       rd;
   logic       wr;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       g_valid;
   logic       g_ready;
   logic [7:0] g_data;
   logic [4:0] g_lat;
   logic       err_timeout;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int         valid_at;
   logic [7:0] g_val;
   int         st_reads;
   logic [17:0] log_q[$];

   fuzzy_eval_sequencer #(.POLL_MAX(20), .LAT_W(5)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .init_req(init_req),
      .cfg_reg_mode(cfg_reg_mode), .cfg_dt_mode(cfg_dt_mode),
      .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
      .g_valid(g_valid), .g_ready(g_ready), .g_data(g_data), .g_lat(g_lat),
      .err_timeout(err_timeout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      rdata = 8'h00;
      if (cs && rd) begin
         if (addr == 8'h00) begin
            rdata = {7'b0, (valid_at != 0) && (st_reads + 1 >= valid_at)};
         end else if (addr == 8'h04) begin
            rdata = g_val;
         end
      end
   end

   always @(posedge clk) begin
      if (cs) begin
         log_q.push_back({rd, wr, addr, rd ? rdata : wdata});
         if (rd && addr == 8'h00) st_reads <= st_reads + 1;
      end
   end

   function automatic logic [17:0] ent(input int i);
      if (i < log_q.size()) return log_q[i];
      return 18'h3FFFF;
   endfunction

   function automatic logic [17:0] W(input logic [7:0] a, input logic [7:0] d);
      return {2'b01, a, d};
   endfunction

   function automatic logic [17:0] R(input logic [7:0] a, input logic [7:0] d);
      return {2'b10, a, d};
   endfunction

   task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one sample and wait for either a result or a timeout pulse.
   task automatic run(input logic [7:0] t, input logic rm, input logic dm,
                      input int va, input logic [7:0] gv,
                      output int lat, output bit got, output bit to);
      @(negedge clk);
      valid_at = va;
      g_val = gv;
      st_reads = 0;
      log_q.delete();
      s_data = t;
      cfg_reg_mode = rm;
      cfg_dt_mode = dm;
      s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      lat = 0;
      got = 0;
      to = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (g_valid) begin
            lat = i; got = 1; break;
         end
         if (err_timeout) begin
            lat = i; to = 1; break;
         end
      end
   endtask

   task automatic take(input int hold, input logic [7:0] gd, input logic [4:0] gl);
      for (int i = 0; i < hold; i++) begin
         ck("hold_valid", 32'(g_valid), 32'd1);
         ck("hold_data", 32'(g_data), 32'(gd));
         ck("hold_lat", 32'(g_lat), 32'(gl));
         @(negedge clk);
      end
      g_ready = 1'b1;
      @(posedge clk);
      #1 g_ready = 1'b0;
      @(negedge clk);
      ck("post_take_idle", 32'(busy), 32'd0);
   endtask

   int lat;
   bit got;
   bit to;
   int n03;

   initial begin
      rst = 1'b1;
      s_valid = 1'b0;
      s_data = 8'h00;
      init_req = 1'b0;
      cfg_reg_mode = 1'b0;
      cfg_dt_mode = 1'b0;
      g_ready = 1'b0;
      valid_at = 0;
      g_val = 8'h00;
      st_reads = 0;
      repeat (2) @(negedge clk);
      ck("rst_outs", {24'b0, cs, rd, wr, s_ready, g_valid, err_timeout, busy, 1'b0}, 32'd0);
      ck("rst_addr_wdata", {16'b0, addr, wdata}, 32'd0);
      ck("rst_g", {19'b0, g_data, g_lat}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      ck("idle_ready", 32'(s_ready), 32'd1);

      // T=0x14, dt_mode=0, VALID on second poll
      run(8'h14, 1'b0, 1'b0, 2, 8'h5A, lat, got, to);
      ck("s1_got", 32'(got), 32'd1);
      ck("s1_lat", 32'(lat), 32'd8);
      ck("s1_len", 32'(log_q.size()), 32'd7);
      ck("s1_e0", 32'(ent(0)), 32'(W(8'h01, 8'h00)));
      ck("s1_e1", 32'(ent(1)), 32'(W(8'h02, 8'h14)));
      ck("s1_e2", 32'(ent(2)), 32'(W(8'h03, 8'h00)));
      ck("s1_e3", 32'(ent(3)), 32'(W(8'h01, 8'h01)));
      ck("s1_e4", 32'(ent(4)), 32'(R(8'h00, 8'h00)));
      ck("s1_e5", 32'(ent(5)), 32'(R(8'h00, 8'h01)));
      ck("s1_e6", 32'(ent(6)), 32'(R(8'h04, 8'h5A)));
      take(5, 8'h5A, 5'd2);

      // saturation: 0x7F then 0x80, then 0x80 again
      run(8'h7F, 1'b0, 1'b0, 1, 8'h11, lat, got, to);
      ck("s2_lat_min", 32'(lat), 32'd7);
      ck("s2_dt", 32'(ent(2)), 32'(W(8'h03, 8'h6B)));
      take(0, 8'h11, 5'd1);
      run(8'h80, 1'b0, 1'b0, 1, 8'h22, lat, got, to);
      ck("s3_dt_sat", 32'(ent(2)), 32'(W(8'h03, 8'h80)));
      take(1, 8'h22, 5'd1);
      run(8'h80, 1'b0, 1'b0, 1, 8'h33, lat, got, to);
      ck("s4_dt_zero", 32'(ent(2)), 32'(W(8'h03, 8'h00)));
      take(0, 8'h33, 5'd1);

      // dt_mode=1, reg_mode=1: dT write skipped
      run(8'h10, 1'b1, 1'b1, 1, 8'h44, lat, got, to);
      ck("s5_lat_min", 32'(lat), 32'd6);
      ck("s5_len", 32'(log_q.size()), 32'd5);
      ck("s5_mode", 32'(ent(0)), 32'(W(8'h01, 8'h06)));
      ck("s5_t", 32'(ent(1)), 32'(W(8'h02, 8'h10)));
      ck("s5_start", 32'(ent(2)), 32'(W(8'h01, 8'h07)));
      n03 = 0;
      foreach (log_q[i]) if (log_q[i][15:8] == 8'h03) n03++;
      ck("s5_no03", 32'(n03), 32'd0);
      take(0, 8'h44, 5'd1);

      // STATUS never VALID -> timeout
      run(8'h20, 1'b0, 1'b0, 0, 8'h00, lat, got, to);
      ck("to_pulse", 32'(to), 32'd1);
      ck("to_no_g", 32'(got), 32'd0);
      ck("to_reads", 32'(st_reads), 32'd20);
      ck("to_lat", 32'(lat), 32'd25);
      @(negedge clk);
      ck("to_one_cycle", 32'(err_timeout), 32'd0);
      ck("to_ready", 32'(s_ready), 32'd1);
      ck("to_no_g2", 32'(g_valid), 32'd0);

      // init_req and s_valid together
      log_q.delete();
      init_req = 1'b1;
      s_valid = 1'b1;
      s_data = 8'h99;
      #1;
      ck("init_blocks_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1 init_req = 1'b0;
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      ck("init_len", 32'(log_q.size()), 32'd1);
      ck("init_wr", 32'(ent(0)), 32'(W(8'h01, 8'h08)));
      ck("init_idle", 32'(busy), 32'd0);
      run(8'h33, 1'b0, 1'b0, 1, 8'h55, lat, got, to);
      ck("init_dt_zero", 32'(ent(2)), 32'(W(8'h03, 8'h00)));
      take(0, 8'h55, 5'd1);

      // reset in the middle of polling
      run(8'h40, 1'b0, 1'b0, 0, 8'h00, lat, got, to);
      ck("rst_mid_to", 32'(to), 32'd1);
      @(negedge clk);
      valid_at = 0;
      st_reads = 0;
      s_data = 8'h41;
      s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cs && rd && addr == 8'h00) begin
            got = 1; break;
         end
      end
      ck("reach_poll", 32'(got), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      ck("rst_cs_drop", 32'(cs), 32'd0);
      ck("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      ck("rst_no_resume", 32'(busy), 32'd0);
      run(8'h50, 1'b0, 1'b0, 1, 8'h66, lat, got, to);
      ck("rst_hist_clr", 32'(ent(2)), 32'(W(8'h03, 8'h00)));
      ck("rst_after_g", 32'(got), 32'd1);
      take(0, 8'h66, 5'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
